// File: rtl/nts_dispatcher_pool.sv
// Receive frame buffer pool: NUM_BUFFERS BRAM buffers used as an in-order ring between MAC RX and the NTS dispatcher.
// Drop statistics counters are built only when NTS_DISPATCHER_POOL_STATS_EN is defined.
module nts_dispatcher_pool #(
  parameter int ADDR_WIDTH  = 10,
  parameter int NUM_BUFFERS = 4,
  parameter int BUF_WIDTH   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic [7:0]            i_rx_data_valid,
  input  logic [63:0]           i_rx_data,
  input  logic                  i_rx_bad_frame,
  input  logic                  i_rx_good_frame,
  input  logic                  i_process_frame,
  output logic                  o_dispatch_packet_available,
  output logic [BUF_WIDTH-1:0]  o_dispatch_buffer,
  output logic [ADDR_WIDTH-1:0] o_dispatch_counter,
  output logic [7:0]            o_dispatch_data_valid,
  input  logic [ADDR_WIDTH-1:0] i_dispatch_raddr,
  output logic [63:0]           o_dispatch_rdata,
  input  logic                  i_dispatch_release,
  output logic [31:0]           o_stat_full_drop,
  output logic [31:0]           o_stat_nodecision_drop,
  output logic [31:0]           o_stat_overrun_drop,
  output logic [31:0]           o_stat_bad_drop
);

  typedef enum logic [1:0] {BUF_EMPTY, BUF_FILL, BUF_READY} buf_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_ACCEPT, RX_DROP} rx_phase_t;

  rx_phase_t             phase_q, phase_d;
  buf_state_t            state_q [NUM_BUFFERS];
  buf_state_t            state_d [NUM_BUFFERS];
  logic [ADDR_WIDTH-1:0] counter_q [NUM_BUFFERS];
  logic [7:0]            dvalid_q [NUM_BUFFERS];
  logic [BUF_WIDTH-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic                  proc_q, proc_d, ovr_q, ovr_d;
  logic                  meta_we;
  logic [ADDR_WIDTH-1:0] counter_d;
  logic                  wr_en_d, wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_d, wr_addr_q;
  logic [BUF_WIDTH-1:0]  wr_buf_q;
  logic [63:0]           wr_data_q;
  logic                  inc_full, inc_nodec, inc_ovr, inc_bad;
  logic                  beat, eof, frame_open;
  logic [63:0]           rd_data [NUM_BUFFERS];

  assign beat = |i_rx_data_valid;
  assign eof  = i_rx_good_frame | i_rx_bad_frame;

  always_comb begin
    phase_d    = phase_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    state_d    = state_q;
    proc_d     = proc_q;
    ovr_d      = ovr_q;
    meta_we    = 1'b0;
    counter_d  = counter_q[wptr_q];
    wr_en_d    = 1'b0;
    wr_addr_d  = '0;
    frame_open = 1'b0;
    inc_full   = 1'b0;
    inc_nodec  = 1'b0;
    inc_ovr    = 1'b0;
    inc_bad    = 1'b0;

    case (phase_q)
      RX_IDLE: begin
        if (beat) begin
          if (state_q[wptr_q] == BUF_EMPTY) begin
            state_d[wptr_q] = BUF_FILL;
            phase_d         = RX_ACCEPT;
            counter_d       = '0;
            meta_we         = 1'b1;
            wr_en_d         = 1'b1;
            wr_addr_d       = '0;
            proc_d          = i_process_frame;
            ovr_d           = 1'b0;
            frame_open      = 1'b1;
          end else begin
            phase_d  = RX_DROP;
            inc_full = 1'b1;
          end
        end
      end
      RX_ACCEPT: begin
        frame_open = 1'b1;
        proc_d     = proc_q | i_process_frame;
        if (beat) begin
          // The last word of the buffer stays intact; further beats only mark overrun.
          if (counter_q[wptr_q] != '1) begin
            counter_d = counter_q[wptr_q] + ADDR_WIDTH'(1);
            meta_we   = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = counter_d;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // End of frame is resolved after any coincident beat has been absorbed.
    if (eof) begin
      if (frame_open) begin
        if (i_rx_bad_frame) begin
          state_d[wptr_q] = BUF_EMPTY;
          inc_bad         = 1'b1;
        end else if (ovr_d) begin
          state_d[wptr_q] = BUF_EMPTY;
          inc_ovr         = 1'b1;
        end else if (!proc_d) begin
          state_d[wptr_q] = BUF_EMPTY;
          inc_nodec       = 1'b1;
        end else begin
          state_d[wptr_q] = BUF_READY;
          wptr_d          = wptr_q + BUF_WIDTH'(1);
        end
      end
      phase_d = RX_IDLE;
      proc_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    // The head is READY while the write buffer is FILL, so these never collide.
    if (i_dispatch_release && state_q[rptr_q] == BUF_READY) begin
      state_d[rptr_q] = BUF_EMPTY;
      rptr_d          = rptr_q + BUF_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      phase_q   <= RX_DROP;
      wptr_q    <= '0;
      rptr_q    <= '0;
      proc_q    <= 1'b0;
      ovr_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_buf_q  <= '0;
      wr_data_q <= '0;
      for (int b = 0; b < NUM_BUFFERS; b++) begin
        state_q[b]   <= BUF_EMPTY;
        counter_q[b] <= '0;
        dvalid_q[b]  <= '0;
      end
    end else begin
      phase_q   <= phase_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      proc_q    <= proc_d;
      ovr_q     <= ovr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_buf_q  <= wptr_q;
      wr_data_q <= i_rx_data;
      for (int b = 0; b < NUM_BUFFERS; b++) begin
        state_q[b] <= state_d[b];
      end
      if (meta_we) begin
        counter_q[wptr_q] <= counter_d;
        dvalid_q[wptr_q]  <= i_rx_data_valid;
      end
    end
  end

  for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_buf
    logic [63:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [63:0] rd_q;
    logic        wr_hit;

    assign wr_hit = wr_en_q && (wr_buf_q == BUF_WIDTH'(g));

    always_ff @(posedge i_clk) begin
      if (wr_hit) begin
        mem[wr_addr_q] <= wr_data_q;
      end
    end

    // A freshly committed head may still have its last word in flight; bypass keeps that read coherent.
    always_ff @(posedge i_clk) begin
      if (i_areset) begin
        rd_q <= '0;
      end else if (wr_hit && wr_addr_q == i_dispatch_raddr) begin
        rd_q <= wr_data_q;
      end else begin
        rd_q <= mem[i_dispatch_raddr];
      end
    end

    assign rd_data[g] = rd_q;
  end

  assign o_dispatch_packet_available = (state_q[rptr_q] == BUF_READY);
  assign o_dispatch_buffer           = rptr_q;
  assign o_dispatch_counter          = counter_q[rptr_q];
  assign o_dispatch_data_valid       = dvalid_q[rptr_q];
  assign o_dispatch_rdata            = rd_data[rptr_q];

`ifdef NTS_DISPATCHER_POOL_STATS_EN
  logic [31:0] stat_full_q, stat_nodec_q, stat_ovr_q, stat_bad_q;

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      stat_full_q  <= '0;
      stat_nodec_q <= '0;
      stat_ovr_q   <= '0;
      stat_bad_q   <= '0;
    end else begin
      if (inc_full)  stat_full_q  <= stat_full_q + 32'd1;
      if (inc_nodec) stat_nodec_q <= stat_nodec_q + 32'd1;
      if (inc_ovr)   stat_ovr_q   <= stat_ovr_q + 32'd1;
      if (inc_bad)   stat_bad_q   <= stat_bad_q + 32'd1;
    end
  end

  assign o_stat_full_drop       = stat_full_q;
  assign o_stat_nodecision_drop = stat_nodec_q;
  assign o_stat_overrun_drop    = stat_ovr_q;
  assign o_stat_bad_drop        = stat_bad_q;
`else
  logic stats_unused;
  assign stats_unused           = inc_full | inc_nodec | inc_ovr | inc_bad;
  assign o_stat_full_drop       = '0;
  assign o_stat_nodecision_drop = '0;
  assign o_stat_overrun_drop    = '0;
  assign o_stat_bad_drop        = '0;
`endif

endmodule

// File: tb/tb_nts_dispatcher_pool.sv
// Directed bench for nts_dispatcher_pool: a default-size pool plus a 16-word pool for the overrun boundary.
module tb_nts_dispatcher_pool;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset;
  logic [7:0]  rx_valid;
  logic [63:0] rx_data;
  logic        rx_bad, rx_good, proc, rel;
  logic [9:0]  raddr;
  logic [3:0]  raddr_s;

  logic        avail, avail_s;
  logic [1:0]  buf_idx, buf_s;
  logic [9:0]  cnt;
  logic [3:0]  cnt_s;
  logic [7:0]  dv, dv_s;
  logic [63:0] rdata, rdata_s;
  logic [31:0] st_full, st_nd, st_ovr, st_bad;
  logic [31:0] st_full_s, st_nd_s, st_ovr_s, st_bad_s;

  int errors = 0;
  int checks = 0;

`ifdef NTS_DISPATCHER_POOL_STATS_EN
  localparam int STAT_ON = 1;
`else
  localparam int STAT_ON = 0;
`endif

  nts_dispatcher_pool #(.ADDR_WIDTH(10), .NUM_BUFFERS(4), .BUF_WIDTH(2)) dut (
    .i_clk(clk), .i_areset(areset), .i_rx_data_valid(rx_valid), .i_rx_data(rx_data),
    .i_rx_bad_frame(rx_bad), .i_rx_good_frame(rx_good), .i_process_frame(proc),
    .o_dispatch_packet_available(avail), .o_dispatch_buffer(buf_idx),
    .o_dispatch_counter(cnt), .o_dispatch_data_valid(dv), .i_dispatch_raddr(raddr),
    .o_dispatch_rdata(rdata), .i_dispatch_release(rel),
    .o_stat_full_drop(st_full), .o_stat_nodecision_drop(st_nd),
    .o_stat_overrun_drop(st_ovr), .o_stat_bad_drop(st_bad)
  );

  nts_dispatcher_pool #(.ADDR_WIDTH(4), .NUM_BUFFERS(4), .BUF_WIDTH(2)) dut_s (
    .i_clk(clk), .i_areset(areset), .i_rx_data_valid(rx_valid), .i_rx_data(rx_data),
    .i_rx_bad_frame(rx_bad), .i_rx_good_frame(rx_good), .i_process_frame(proc),
    .o_dispatch_packet_available(avail_s), .o_dispatch_buffer(buf_s),
    .o_dispatch_counter(cnt_s), .o_dispatch_data_valid(dv_s), .i_dispatch_raddr(raddr_s),
    .o_dispatch_rdata(rdata_s), .i_dispatch_release(rel),
    .o_stat_full_drop(st_full_s), .o_stat_nodecision_drop(st_nd_s),
    .o_stat_overrun_drop(st_ovr_s), .o_stat_bad_drop(st_bad_s)
  );

  function automatic logic [63:0] fdata(input int id, input int b);
    return {8'hA5, id[7:0], 16'h0000, b[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rx_valid = 8'h00; rx_data = 64'h0; rx_bad = 1'b0; rx_good = 1'b0; proc = 1'b0; rel = 1'b0;
  endtask

  // After reset the RX side discards until an end of frame; a bare bad pulse re-arms it.
  task automatic do_reset();
    areset = 1'b1; idle_inputs(); raddr = '0; raddr_s = '0;
    step(); step();
    areset = 1'b0;
    rx_bad = 1'b1; step(); rx_bad = 1'b0;
  endtask

  // mode: 0 never process, 1 process on first beat, 2 process on good cycle only.
  task automatic send_frame(input int id, input int n, input int mode, input bit bad,
                            input bit rel_last, input bit gap);
    for (int b = 0; b < n; b++) begin
      rx_valid = (b == n - 1) ? 8'h0F : 8'hFF;
      rx_data  = fdata(id, b);
      proc     = (mode == 1 && b == 0) || (mode == 2 && b == n - 1);
      rx_good  = (b == n - 1) && !bad;
      rx_bad   = (b == n - 1) && bad;
      rel      = (b == n - 1) && rel_last;
      step();
    end
    idle_inputs();
    if (gap) step();
  endtask

  task automatic release_head();
    rel = 1'b1; step(); rel = 1'b0;
  endtask

  task automatic read(input int a);
    raddr = a[9:0]; raddr_s = a[3:0]; step();
  endtask

  task automatic test_reset();
    areset = 1'b1; idle_inputs(); raddr = '0; raddr_s = '0;
    step(); step();
    checks++; if (avail !== 1'b0) begin errors++; $display("FAIL reset_avail: got %0d want 0", avail); end
    checks++; if (buf_idx !== 2'd0) begin errors++; $display("FAIL reset_buffer: got %0d want 0", buf_idx); end
    checks++; if (cnt !== 10'd0) begin errors++; $display("FAIL reset_counter: got %0d want 0", cnt); end
    checks++; if (dv !== 8'h00) begin errors++; $display("FAIL reset_dv: got %0h want 0", dv); end
    checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %0h want 0", rdata); end
    checks++; if ((st_full | st_nd | st_ovr | st_bad) !== 32'h0) begin errors++; $display("FAIL reset_stats: got %0h want 0", st_full | st_nd | st_ovr | st_bad); end
    checks++; if (avail_s !== 1'b0) begin errors++; $display("FAIL reset_avail_small: got %0d want 0", avail_s); end
    areset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    send_frame(1, 10, 1, 1'b0, 1'b0, 1'b1);
    send_frame(2, 20, 1, 1'b0, 1'b0, 1'b1);
    send_frame(3, 30, 1, 1'b0, 1'b0, 1'b1);
    checks++; if (avail !== 1'b1) begin errors++; $display("FAIL basic_avail: got %0d want 1", avail); end
    checks++; if (buf_idx !== 2'd0) begin errors++; $display("FAIL basic_buffer0: got %0d want 0", buf_idx); end
    checks++; if (cnt !== 10'd9) begin errors++; $display("FAIL basic_counter0: got %0d want 9", cnt); end
    checks++; if (dv !== 8'h0F) begin errors++; $display("FAIL basic_dv0: got %0h want f", dv); end
    read(0);
    checks++; if (rdata !== fdata(1, 0)) begin errors++; $display("FAIL basic_data_f1w0: got %0h want %0h", rdata, fdata(1, 0)); end
    read(9);
    checks++; if (rdata !== fdata(1, 9)) begin errors++; $display("FAIL basic_data_f1w9: got %0h want %0h", rdata, fdata(1, 9)); end
    release_head();
    checks++; if (buf_idx !== 2'd1) begin errors++; $display("FAIL basic_buffer1: got %0d want 1", buf_idx); end
    checks++; if (cnt !== 10'd19) begin errors++; $display("FAIL basic_counter1: got %0d want 19", cnt); end
    read(19);
    checks++; if (rdata !== fdata(2, 19)) begin errors++; $display("FAIL basic_data_f2w19: got %0h want %0h", rdata, fdata(2, 19)); end
    release_head();
    checks++; if (cnt !== 10'd29) begin errors++; $display("FAIL basic_counter2: got %0d want 29", cnt); end
    read(0);
    checks++; if (rdata !== fdata(3, 0)) begin errors++; $display("FAIL basic_data_f3w0: got %0h want %0h", rdata, fdata(3, 0)); end
    release_head();
    checks++; if (avail !== 1'b0) begin errors++; $display("FAIL basic_drained: got %0d want 0", avail); end
    checks++; if (buf_idx !== 2'd3) begin errors++; $display("FAIL basic_buffer3: got %0d want 3", buf_idx); end
  endtask

  task automatic test_full();
    do_reset();
    for (int f = 0; f < 5; f++) send_frame(10 + f, 3, 1, 1'b0, 1'b0, 1'b1);
    checks++; if (avail !== 1'b1) begin errors++; $display("FAIL full_avail: got %0d want 1", avail); end
    checks++; if (st_full !== 32'(STAT_ON)) begin errors++; $display("FAIL full_stat: got %0d want %0d", st_full, STAT_ON); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (buf_idx !== 2'(i)) begin errors++; $display("FAIL full_head%0d: got %0d want %0d", i, buf_idx, i); end
      read(1);
      checks++; if (rdata !== fdata(10 + i, 1)) begin errors++; $display("FAIL full_data%0d: got %0h want %0h", i, rdata, fdata(10 + i, 1)); end
      release_head();
    end
    checks++; if (avail !== 1'b0) begin errors++; $display("FAIL full_drained: got %0d want 0", avail); end
    release_head();
    send_frame(15, 4, 1, 1'b0, 1'b0, 1'b1);
    checks++; if (avail !== 1'b1 || buf_idx !== 2'd0) begin errors++; $display("FAIL full_idle_release: got avail=%0d buf=%0d want avail=1 buf=0", avail, buf_idx); end
    checks++; if (cnt !== 10'd3) begin errors++; $display("FAIL full_wrap_counter: got %0d want 3", cnt); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(20, 17, 1, 1'b0, 1'b0, 1'b1);
    checks++; if (avail_s !== 1'b0) begin errors++; $display("FAIL ovr_not_committed: got %0d want 0", avail_s); end
    checks++; if (st_ovr_s !== 32'(STAT_ON)) begin errors++; $display("FAIL ovr_stat: got %0d want %0d", st_ovr_s, STAT_ON); end
    send_frame(21, 16, 1, 1'b0, 1'b0, 1'b1);
    checks++; if (avail_s !== 1'b1 || buf_s !== 2'd0) begin errors++; $display("FAIL ovr_wptr_kept: got avail=%0d buf=%0d want avail=1 buf=0", avail_s, buf_s); end
    checks++; if (cnt_s !== 4'd15) begin errors++; $display("FAIL ovr_full_buffer_counter: got %0d want 15", cnt_s); end
    read(15);
    checks++; if (rdata_s !== fdata(21, 15)) begin errors++; $display("FAIL ovr_last_word: got %0h want %0h", rdata_s, fdata(21, 15)); end
  endtask

  task automatic test_nodecision();
    do_reset();
    send_frame(30, 4, 0, 1'b0, 1'b0, 1'b1);
    checks++; if (avail !== 1'b0) begin errors++; $display("FAIL nodec_dropped: got %0d want 0", avail); end
    checks++; if (st_nd !== 32'(STAT_ON)) begin errors++; $display("FAIL nodec_stat: got %0d want %0d", st_nd, STAT_ON); end
    send_frame(31, 4, 2, 1'b0, 1'b0, 1'b1);
    checks++; if (avail !== 1'b1 || buf_idx !== 2'd0) begin errors++; $display("FAIL nodec_late_process: got avail=%0d buf=%0d want avail=1 buf=0", avail, buf_idx); end
    read(3);
    checks++; if (rdata !== fdata(31, 3)) begin errors++; $display("FAIL nodec_data: got %0h want %0h", rdata, fdata(31, 3)); end
  endtask

  task automatic test_bad();
    do_reset();
    send_frame(40, 3, 1, 1'b1, 1'b0, 1'b1);
    checks++; if (avail !== 1'b0) begin errors++; $display("FAIL bad_dropped: got %0d want 0", avail); end
    checks++; if (st_bad !== 32'(STAT_ON)) begin errors++; $display("FAIL bad_stat: got %0d want %0d", st_bad, STAT_ON); end
    send_frame(41, 5, 1, 1'b0, 1'b0, 1'b1);
    checks++; if (avail !== 1'b1 || buf_idx !== 2'd0 || cnt !== 10'd4) begin errors++; $display("FAIL bad_reuse: got avail=%0d buf=%0d cnt=%0d want 1/0/4", avail, buf_idx, cnt); end
    read(2);
    checks++; if (rdata !== fdata(41, 2)) begin errors++; $display("FAIL bad_next_data: got %0h want %0h", rdata, fdata(41, 2)); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int b = 0; b < 12; b++) begin
      rx_valid = 8'hFF;
      rx_data  = fdata(50, b);
      proc     = (b == 0) || (b == 6);
      rx_good  = (b == 11);
      areset   = (b == 5);
      step();
    end
    idle_inputs(); areset = 1'b0; step();
    checks++; if (avail !== 1'b0) begin errors++; $display("FAIL rstmid_tail_ignored: got avail=%0d cnt=%0d want avail=0", avail, cnt); end
    send_frame(51, 5, 1, 1'b0, 1'b0, 1'b1);
    checks++; if (avail !== 1'b1 || buf_idx !== 2'd0 || cnt !== 10'd4) begin errors++; $display("FAIL rstmid_next_frame: got avail=%0d buf=%0d cnt=%0d want 1/0/4", avail, buf_idx, cnt); end
    read(0);
    checks++; if (rdata !== fdata(51, 0)) begin errors++; $display("FAIL rstmid_addr0: got %0h want %0h", rdata, fdata(51, 0)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(60, 1, 1, 1'b0, 1'b0, 1'b0);
    send_frame(61, 4, 2, 1'b0, 1'b0, 1'b1);
    checks++; if (avail !== 1'b1 || buf_idx !== 2'd0 || cnt !== 10'd0) begin errors++; $display("FAIL b2b_single_beat: got avail=%0d buf=%0d cnt=%0d want 1/0/0", avail, buf_idx, cnt); end
    checks++; if (dv !== 8'h0F) begin errors++; $display("FAIL b2b_single_dv: got %0h want f", dv); end
    read(0);
    checks++; if (rdata !== fdata(60, 0)) begin errors++; $display("FAIL b2b_single_data: got %0h want %0h", rdata, fdata(60, 0)); end
    send_frame(62, 2, 1, 1'b0, 1'b1, 1'b1);
    checks++; if (buf_idx !== 2'd1 || cnt !== 10'd3) begin errors++; $display("FAIL b2b_release_commit: got buf=%0d cnt=%0d want 1/3", buf_idx, cnt); end
    read(3);
    checks++; if (rdata !== fdata(61, 3)) begin errors++; $display("FAIL b2b_second_data: got %0h want %0h", rdata, fdata(61, 3)); end
    release_head();
    checks++; if (avail !== 1'b1 || buf_idx !== 2'd2 || cnt !== 10'd1) begin errors++; $display("FAIL b2b_third_head: got avail=%0d buf=%0d cnt=%0d want 1/2/1", avail, buf_idx, cnt); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal;
  end

  initial begin
    idle_inputs(); areset = 1'b1; raddr = '0; raddr_s = '0;
    test_reset();
    test_basic();
    test_full();
    test_overrun();
    test_nodecision();
    test_bad();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
